// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and default sizing for the two-requester RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } requester_id;

  localparam int DEFAULT_ADDR_WIDTH = 15;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_MAX_WAIT   = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Request, response, RAM-side and profiling signals of the memory port arbiter.
interface memory_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  Req0Valid, Req0Ready, Req0Write;
  logic [ADDR_WIDTH-1:0] Req0Address;
  logic [BE_WIDTH-1:0]   Req0ByteEnable;
  logic [DATA_WIDTH-1:0] Req0WriteData;
  logic                  Rsp0Valid;
  logic [DATA_WIDTH-1:0] Rsp0ReadData;

  logic                  Req1Valid, Req1Ready, Req1Write;
  logic [ADDR_WIDTH-1:0] Req1Address;
  logic [BE_WIDTH-1:0]   Req1ByteEnable;
  logic [DATA_WIDTH-1:0] Req1WriteData;
  logic                  Rsp1Valid;
  logic [DATA_WIDTH-1:0] Rsp1ReadData;

  logic                  MemEnable, MemWriteEnable;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [BE_WIDTH-1:0]   MemByteEnable;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemReadData;

  logic [CNT_WIDTH-1:0]  GrantCount0, GrantCount1, ConflictCount;

  modport master (
    output Req0Valid, Req0Write, Req0Address, Req0ByteEnable, Req0WriteData,
    output Req1Valid, Req1Write, Req1Address, Req1ByteEnable, Req1WriteData,
    output MemReadData,
    input  Req0Ready, Rsp0Valid, Rsp0ReadData, Req1Ready, Rsp1Valid, Rsp1ReadData,
    input  MemEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData,
    input  GrantCount0, GrantCount1, ConflictCount
  );

  modport slave (
    input  Req0Valid, Req0Write, Req0Address, Req0ByteEnable, Req0WriteData,
    input  Req1Valid, Req1Write, Req1Address, Req1ByteEnable, Req1WriteData,
    input  MemReadData,
    output Req0Ready, Rsp0Valid, Rsp0ReadData, Req1Ready, Rsp1Valid, Rsp1ReadData,
    output MemEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData,
    output GrantCount0, GrantCount1, ConflictCount
  );

endinterface

// File: rtl/memory_port_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Increment,
  output logic [WIDTH-1:0] Count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count state: advance on Increment unless already saturated
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
    end else if (Increment && (Count != '1)) begin
      Count <= Count + ONE;
    end else begin
      Count <= Count;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-cycle-read RAM port between the CPU (fixed priority) and
// a DMA engine whose wait is bounded, and routes read data back by tag.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input logic                  Clock,
  input logic                  Reset,
  memory_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic        grant0_s, grant1_s;
  logic [3:0]  wait_count_r;
  logic        rsp_pending_r;
  requester_id rsp_tag_r;

  // Same-cycle grant; port 1 wins only when port 0 is idle or it has waited out
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (Reset) begin
      grant1_s = bus.Req1Valid && (!bus.Req0Valid || (wait_count_r == MAX_WAIT_C));
      grant0_s = bus.Req0Valid && !grant1_s;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign bus.Req0Ready = grant0_s;
  assign bus.Req1Ready = grant1_s;

  // RAM-side mux from the granted port, zeros when idle
  always_comb begin
    bus.MemEnable      = 1'b0;
    bus.MemWriteEnable = 1'b0;
    bus.MemAddress     = '0;
    bus.MemByteEnable  = '0;
    bus.MemWriteData   = '0;
    if (grant1_s) begin
      bus.MemEnable      = 1'b1;
      bus.MemWriteEnable = bus.Req1Write;
      bus.MemAddress     = bus.Req1Address;
      bus.MemByteEnable  = bus.Req1ByteEnable;
      bus.MemWriteData   = bus.Req1WriteData;
    end else if (grant0_s) begin
      bus.MemEnable      = 1'b1;
      bus.MemWriteEnable = bus.Req0Write;
      bus.MemAddress     = bus.Req0Address;
      bus.MemByteEnable  = bus.Req0ByteEnable;
      bus.MemWriteData   = bus.Req0WriteData;
    end else begin
      bus.MemEnable      = 1'b0;
    end
  end

  // Starvation counter: consecutive cycles port 1 has been denied
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_count_r <= 4'd0;
    end else if (grant1_s || !bus.Req1Valid) begin
      wait_count_r <= 4'd0;
    end else if (wait_count_r != MAX_WAIT_C) begin
      wait_count_r <= wait_count_r + 4'd1;
    end else begin
      wait_count_r <= wait_count_r;
    end
  end

  // Remember which port owns the read data arriving next cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rsp_pending_r <= 1'b0;
      rsp_tag_r     <= REQ_CPU;
    end else begin
      rsp_pending_r <= (grant0_s && !bus.Req0Write) || (grant1_s && !bus.Req1Write);
      rsp_tag_r     <= grant1_s ? REQ_DMA : REQ_CPU;
    end
  end

  // Steer RAM read data to the tagged port only
  always_comb begin
    bus.Rsp0Valid    = 1'b0;
    bus.Rsp0ReadData = '0;
    bus.Rsp1Valid    = 1'b0;
    bus.Rsp1ReadData = '0;
    if (rsp_pending_r && (rsp_tag_r == REQ_CPU)) begin
      bus.Rsp0Valid    = 1'b1;
      bus.Rsp0ReadData = bus.MemReadData;
    end else if (rsp_pending_r && (rsp_tag_r == REQ_DMA)) begin
      bus.Rsp1Valid    = 1'b1;
      bus.Rsp1ReadData = bus.MemReadData;
    end else begin
      bus.Rsp0Valid    = 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_grant_count0 (
    .Clock(Clock), .Reset(Reset), .Increment(grant0_s), .Count(bus.GrantCount0)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_grant_count1 (
    .Clock(Clock), .Reset(Reset), .Increment(grant1_s), .Count(bus.GrantCount1)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_conflict_count (
    .Clock(Clock), .Reset(Reset), .Increment(bus.Req0Valid && bus.Req1Valid),
    .Count(bus.ConflictCount)
  );

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized bench for memory_port_arbiter against a RAM model
// and a transaction-level reference of the arbitration rules.
module tb_memory_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MAXW = DEFAULT_MAX_WAIT;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  memory_port_arbiter_if bus ();

  memory_port_arbiter dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  logic [31:0] ram    [int];
  logic [31:0] shadow [int];

  function automatic logic [31:0] init_word(int a);
    return 32'(32'h5A00_0000 ^ (a * 32'h0001_0101));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_rd(int a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] shadow_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // Synchronous RAM with one-cycle read latency
  always @(posedge Clock) begin
    if (bus.MemEnable) begin
      if (bus.MemWriteEnable)
        ram[int'(bus.MemAddress)] = merge(ram_rd(int'(bus.MemAddress)), bus.MemWriteData, bus.MemByteEnable);
      else
        bus.MemReadData <= ram_rd(int'(bus.MemAddress));
    end
  end

  task automatic clear_inputs();
    bus.Req0Valid = 1'b0; bus.Req0Write = 1'b0; bus.Req0Address = '0;
    bus.Req0ByteEnable = '0; bus.Req0WriteData = '0;
    bus.Req1Valid = 1'b0; bus.Req1Write = 1'b0; bus.Req1Address = '0;
    bus.Req1ByteEnable = '0; bus.Req1WriteData = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.Req0Valid = 1'b1; bus.Req1Valid = 1'b1; bus.Req1Write = 1'b1;
    #1;
    checks++;
    if ({bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable, bus.Rsp0Valid, bus.Rsp1Valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable, bus.Rsp0Valid, bus.Rsp1Valid});
    end
    checks++;
    if ({bus.GrantCount0, bus.GrantCount1, bus.ConflictCount} !== 48'h0) begin
      errors++;
      $display("FAIL reset_counters: got %h expected 0", {bus.GrantCount0, bus.GrantCount1, bus.ConflictCount});
    end
    clear_inputs();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic preset_word(logic [14:0] a, logic [31:0] d);
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b1; bus.Req0Address = a;
    bus.Req0ByteEnable = 4'hF; bus.Req0WriteData = d;
    shadow[int'(a)] = d;
    @(negedge Clock);
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0010;
    #1;
    checks++;
    if ({bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable, bus.MemAddress} !== {4'b1010, 15'h0010}) begin
      errors++;
      $display("FAIL single_read_grant: got %b/%h expected 1010/0010",
               {bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable}, bus.MemAddress);
    end
    @(negedge Clock);
    clear_inputs();
    #1;
    checks++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.Rsp0ReadData, bus.Rsp1ReadData} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL single_read_rsp: got %b %h %h expected 10 deadbeef 0",
               {bus.Rsp0Valid, bus.Rsp1Valid}, bus.Rsp0ReadData, bus.Rsp1ReadData);
    end
    checks++;
    if (bus.GrantCount0 !== 16'd1) begin
      errors++;
      $display("FAIL single_read_count: got %0d expected 1", bus.GrantCount0);
    end
    @(negedge Clock);
  endtask

  task automatic test_contention();
    logic exp1;
    do_reset();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0003;
    bus.Req1Valid = 1'b1; bus.Req1Address = 15'h0004;
    for (int c = 0; c < 20; c++) begin
      exp1 = ((c % (MAXW + 1)) == MAXW);
      #1;
      checks++;
      if ({bus.Req0Ready, bus.Req1Ready} !== {!exp1, exp1}) begin
        errors++;
        $display("FAIL contention_cycle%0d: got %b expected %b", c, {bus.Req0Ready, bus.Req1Ready}, {!exp1, exp1});
      end
      @(negedge Clock);
    end
    clear_inputs();
    #1;
    checks++;
    if ({bus.GrantCount0, bus.GrantCount1, bus.ConflictCount} !== {16'd16, 16'd4, 16'd20}) begin
      errors++;
      $display("FAIL contention_counts: got %0d/%0d/%0d expected 16/4/20",
               bus.GrantCount0, bus.GrantCount1, bus.ConflictCount);
    end
    @(negedge Clock);
  endtask

  task automatic test_write_bytes();
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b1; bus.Req1Address = 15'h0020;
    bus.Req1ByteEnable = 4'b0001; bus.Req1WriteData = 32'h0000_00AB;
    #1;
    checks++;
    if ({bus.Req1Ready, bus.MemWriteEnable, bus.MemByteEnable} !== {2'b11, 4'b0001}) begin
      errors++;
      $display("FAIL write_grant: got %b expected 110001", {bus.Req1Ready, bus.MemWriteEnable, bus.MemByteEnable});
    end
    @(negedge Clock);
    clear_inputs();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0020;
    #1;
    checks++;
    if (bus.Rsp1Valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rsp: got %b expected 0", bus.Rsp1Valid);
    end
    @(negedge Clock);
    clear_inputs();
    #1;
    checks++;
    if ({bus.Rsp0Valid, bus.Rsp0ReadData} !== {1'b1, 32'h1122_33AB}) begin
      errors++;
      $display("FAIL write_merge: got %b %h expected 1 112233ab", bus.Rsp0Valid, bus.Rsp0ReadData);
    end
    shadow[32'h20] = 32'h1122_33AB;
    @(negedge Clock);
  endtask

  task automatic test_alternating();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0001;
    @(negedge Clock);
    clear_inputs();
    bus.Req1Valid = 1'b1; bus.Req1Address = 15'h0002;
    #1;
    checks++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.Rsp0ReadData} !== {2'b10, shadow_rd(1)}) begin
      errors++;
      $display("FAIL alt_rsp0_a: got %b %h expected 10 %h", {bus.Rsp0Valid, bus.Rsp1Valid}, bus.Rsp0ReadData, shadow_rd(1));
    end
    @(negedge Clock);
    clear_inputs();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0003;
    #1;
    checks++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.Rsp1ReadData} !== {2'b01, shadow_rd(2)}) begin
      errors++;
      $display("FAIL alt_rsp1: got %b %h expected 01 %h", {bus.Rsp0Valid, bus.Rsp1Valid}, bus.Rsp1ReadData, shadow_rd(2));
    end
    @(negedge Clock);
    clear_inputs();
    #1;
    checks++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.Rsp0ReadData} !== {2'b10, shadow_rd(3)}) begin
      errors++;
      $display("FAIL alt_rsp0_b: got %b %h expected 10 %h", {bus.Rsp0Valid, bus.Rsp1Valid}, bus.Rsp0ReadData, shadow_rd(3));
    end
    @(negedge Clock);
  endtask

  task automatic test_random(int ncycles);
    logic        p0_busy, p1_busy, g0, g1, exp_rv, exp_p1;
    logic        w0, w1;
    logic [14:0] a0, a1, ea;
    logic [3:0]  be0, be1, ebe;
    logic [31:0] d0, d1, ed, exp_data;
    int          denied, gc0, gc1, cc;
    do_reset();
    p0_busy = 1'b0; p1_busy = 1'b0; exp_rv = 1'b0; exp_p1 = 1'b0; exp_data = '0;
    denied = 0; gc0 = 0; gc1 = 0; cc = 0;
    w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; be0 = '0; be1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < ncycles; c++) begin
      if (!p0_busy && ($urandom_range(0, 3) != 0)) begin
        p0_busy = 1'b1; w0 = 1'($urandom_range(0, 1)); a0 = 15'($urandom_range(0, 31));
        be0 = 4'($urandom); d0 = $urandom;
      end
      if (!p1_busy && ($urandom_range(0, 2) != 0)) begin
        p1_busy = 1'b1; w1 = 1'($urandom_range(0, 1)); a1 = 15'($urandom_range(0, 31));
        be1 = 4'($urandom); d1 = $urandom;
      end
      bus.Req0Valid = p0_busy; bus.Req0Write = w0; bus.Req0Address = a0;
      bus.Req0ByteEnable = be0; bus.Req0WriteData = d0;
      bus.Req1Valid = p1_busy; bus.Req1Write = w1; bus.Req1Address = a1;
      bus.Req1ByteEnable = be1; bus.Req1WriteData = d1;
      g1 = p1_busy && (!p0_busy || denied == MAXW);
      g0 = p0_busy && !g1;
      ea  = g1 ? a1  : (g0 ? a0  : 15'h0);
      ebe = g1 ? be1 : (g0 ? be0 : 4'h0);
      ed  = g1 ? d1  : (g0 ? d0  : 32'h0);
      #1;
      checks++;
      if ({bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable} !== {g0, g1, g0 | g1, (g1 & w1) | (g0 & w0)}) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: got %b expected %b", c,
                 {bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable}, {g0, g1, g0 | g1, (g1 & w1) | (g0 & w0)});
      end
      checks++;
      if ({bus.MemAddress, bus.MemByteEnable, bus.MemWriteData} !== {ea, ebe, ed}) begin
        errors++;
        $display("FAIL rand_mem c%0d: got %h/%h/%h expected %h/%h/%h", c,
                 bus.MemAddress, bus.MemByteEnable, bus.MemWriteData, ea, ebe, ed);
      end
      checks++;
      if ({bus.Rsp0Valid, bus.Rsp1Valid} !== {exp_rv && !exp_p1, exp_rv && exp_p1}) begin
        errors++;
        $display("FAIL rand_rspv c%0d: got %b expected %b", c, {bus.Rsp0Valid, bus.Rsp1Valid}, {exp_rv && !exp_p1, exp_rv && exp_p1});
      end
      checks++;
      if ({bus.Rsp0ReadData, bus.Rsp1ReadData} !== {(exp_rv && !exp_p1) ? exp_data : 32'h0, (exp_rv && exp_p1) ? exp_data : 32'h0}) begin
        errors++;
        $display("FAIL rand_rspd c%0d: got %h/%h expected data %h to port %0d", c,
                 bus.Rsp0ReadData, bus.Rsp1ReadData, exp_data, exp_p1);
      end
      checks++;
      if ({bus.GrantCount0, bus.GrantCount1, bus.ConflictCount} !== {16'(gc0), 16'(gc1), 16'(cc)}) begin
        errors++;
        $display("FAIL rand_counts c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                 bus.GrantCount0, bus.GrantCount1, bus.ConflictCount, gc0, gc1, cc);
      end
      if (p0_busy && p1_busy && cc < 65535) cc++;
      if (g0 && gc0 < 65535) gc0++;
      if (g1 && gc1 < 65535) gc1++;
      if (!p1_busy || g1) denied = 0;
      else if (denied < MAXW) denied++;
      exp_rv = (g0 && !w0) || (g1 && !w1);
      exp_p1 = g1;
      if (g1 && !w1) exp_data = shadow_rd(int'(a1));
      if (g0 && !w0) exp_data = shadow_rd(int'(a0));
      if (g1 && w1) shadow[int'(a1)] = merge(shadow_rd(int'(a1)), d1, be1);
      if (g0 && w0) shadow[int'(a0)] = merge(shadow_rd(int'(a0)), d0, be0);
      if (g0) p0_busy = 1'b0;
      if (g1) p1_busy = 1'b0;
      @(negedge Clock);
      if (errors > 40) break;
    end
    clear_inputs();
    @(negedge Clock);
  endtask

  task automatic test_reset_midcycle();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0005;
    @(posedge Clock);
    #2;
    checks++;
    if (bus.Rsp0Valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_rsp: got %b expected 1", bus.Rsp0Valid);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable, bus.Rsp0Valid, bus.Rsp1Valid} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_drop: got %b expected 000000",
               {bus.Req0Ready, bus.Req1Ready, bus.MemEnable, bus.MemWriteEnable, bus.Rsp0Valid, bus.Rsp1Valid});
    end
    @(negedge Clock);
    clear_inputs();
    @(negedge Clock);
    Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.GrantCount0, bus.GrantCount1, bus.ConflictCount} !== 50'h0) begin
        errors++;
        $display("FAIL midreset_after c%0d: rsp %b counts %0d/%0d/%0d expected all 0", c,
                 {bus.Rsp0Valid, bus.Rsp1Valid}, bus.GrantCount0, bus.GrantCount1, bus.ConflictCount);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.Req0Valid = 1'b1; bus.Req0Address = 15'h0000;
    for (int i = 1; i <= 65540; i++) begin
      @(negedge Clock);
      if (i == 65534) begin
        checks++;
        if (bus.GrantCount0 !== 16'hFFFE) begin
          errors++;
          $display("FAIL sat_before: got %h expected fffe", bus.GrantCount0);
        end
      end
    end
    #1;
    checks++;
    if ({bus.GrantCount0, bus.GrantCount1, bus.ConflictCount, bus.Req0Ready} !== {16'hFFFF, 16'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL sat_hold: got %h/%h/%h ready %b expected ffff/0000/0000 ready 1",
               bus.GrantCount0, bus.GrantCount1, bus.ConflictCount, bus.Req0Ready);
    end
    checks++;
    if (dut.wait_count_r !== 4'd0) begin
      errors++;
      $display("FAIL sat_wait: got %0d expected 0", dut.wait_count_r);
    end
    clear_inputs();
    @(negedge Clock);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    preset_word(15'h0010, 32'hDEAD_BEEF);
    preset_word(15'h0020, 32'h1122_3344);
    test_single_read();
    test_contention();
    test_write_bytes();
    test_alternating();
    test_random(2000);
    test_reset_midcycle();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
